// File: rtl/rfile_sb.sv
// Multi-port register file with per-register busy (scoreboard) bits and a busy counter.
// Optional same-cycle write-to-read forwarding is enabled by defining RFILE_BYPASS_EN.
module rfile_sb #(
  parameter int NREGS       = 32,
  parameter int ADDR_WIDTH  = $clog2(NREGS),
  parameter int DATA_WIDTH  = 32,
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 4,
  parameter int RSV_PORTS   = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [ADDR_WIDTH-1:0]         rd_addr   [READ_PORTS],
  output logic [DATA_WIDTH-1:0]         rd_data   [READ_PORTS],
  output logic [READ_PORTS-1:0]         rd_busy,
  input  logic [ADDR_WIDTH-1:0]         wr_addr   [WRITE_PORTS],
  input  logic [WRITE_PORTS-1:0]        wr_enable,
  input  logic [DATA_WIDTH-1:0]         wr_data   [WRITE_PORTS],
  input  logic [RSV_PORTS-1:0]          rsv_valid,
  input  logic [ADDR_WIDTH-1:0]         rsv_addr  [RSV_PORTS],
  output logic [$clog2(NREGS+1)-1:0]    busy_count
);

  localparam int CNT_WIDTH = $clog2(NREGS + 1);
  localparam int FIRST_REG = (ZERO_REG != 0) ? 1 : 0;

  logic [DATA_WIDTH-1:0] regs_r   [NREGS];
  logic [DATA_WIDTH-1:0] regs_nxt_s [NREGS];
  logic [NREGS-1:0]      busy_r;
  logic [NREGS-1:0]      busy_nxt_s;
  logic [NREGS-1:0]      set_vec_s;
  logic [NREGS-1:0]      clr_vec_s;
  logic [CNT_WIDTH-1:0]  busy_count_r;
  logic [CNT_WIDTH-1:0]  count_nxt_s;

  // An address names a real, writable register (in range and not the hardwired zero).
  function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == {ADDR_WIDTH{1'b0}}));
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NREGS-1:0] bits);
    logic [CNT_WIDTH-1:0] n;
    n = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      n = n + {{(CNT_WIDTH-1){1'b0}}, bits[i]};
    end
    return n;
  endfunction

  // Next register contents and busy bits; later write ports override earlier ones,
  // and a reservation always beats a release of the same register.
  always_comb begin
    regs_nxt_s = regs_r;
    set_vec_s  = {NREGS{1'b0}};
    clr_vec_s  = {NREGS{1'b0}};
    for (int r = FIRST_REG; r < NREGS; r++) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        regs_nxt_s[r] = (wr_enable[p] && (wr_addr[p] == ADDR_WIDTH'(r))) ? wr_data[p] : regs_nxt_s[r];
        clr_vec_s[r]  = clr_vec_s[r] | (wr_enable[p] && (wr_addr[p] == ADDR_WIDTH'(r)));
      end
      for (int p = 0; p < RSV_PORTS; p++) begin
        set_vec_s[r] = set_vec_s[r] | (rsv_valid[p] && (rsv_addr[p] == ADDR_WIDTH'(r)));
      end
    end
    busy_nxt_s  = set_vec_s | (busy_r & ~clr_vec_s);
    count_nxt_s = popcount(busy_nxt_s);
  end

  // Architectural state: register array, busy bits and their population count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {DATA_WIDTH{1'b0}};
      end
      busy_r       <= {NREGS{1'b0}};
      busy_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      regs_r       <= regs_nxt_s;
      busy_r       <= busy_nxt_s;
      busy_count_r <= count_nxt_s;
    end
  end

  assign busy_count = busy_count_r;

  // Zero-latency read ports, optionally forwarding same-cycle writeback data.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a_s;
    logic                  byp_s;
    logic                  rhit_s;
    a_s    = {ADDR_WIDTH{1'b0}};
    byp_s  = 1'b0;
    rhit_s = 1'b0;
    rd_busy = {READ_PORTS{1'b0}};
    for (int q = 0; q < READ_PORTS; q++) begin
      a_s = rd_addr[q];
      if (addr_live(a_s)) begin
        rd_data[q] = regs_r[a_s];
        rd_busy[q] = busy_r[a_s];
      end else begin
        rd_data[q] = {DATA_WIDTH{1'b0}};
        rd_busy[q] = 1'b0;
      end
`ifdef RFILE_BYPASS_EN
      byp_s  = 1'b0;
      rhit_s = 1'b0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
        rd_data[q] = (wr_enable[p] && (wr_addr[p] == a_s) && addr_live(a_s)) ? wr_data[p] : rd_data[q];
        byp_s      = byp_s | (wr_enable[p] && (wr_addr[p] == a_s) && addr_live(a_s));
      end
      for (int p = 0; p < RSV_PORTS; p++) begin
        rhit_s = rhit_s | (rsv_valid[p] && (rsv_addr[p] == a_s));
      end
      rd_busy[q] = byp_s ? rhit_s : rd_busy[q];
`else
      byp_s  = 1'b0;
      rhit_s = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_rfile_sb.sv
// Bench for rfile_sb: directed scenarios then random traffic checked against an
// array-based model of the register file and scoreboard.
module tb_rfile_sb;

  localparam int NR = 32;
  localparam int RP = 4;
  localparam int WP = 4;
  localparam int SP = 2;

  logic        clock;
  logic        reset_n;
  logic [4:0]  rd_addr   [RP];
  logic [31:0] rd_data   [RP];
  logic [RP-1:0] rd_busy;
  logic [4:0]  wr_addr   [WP];
  logic [WP-1:0] wr_enable;
  logic [31:0] wr_data   [WP];
  logic [SP-1:0] rsv_valid;
  logic [4:0]  rsv_addr  [SP];
  logic [5:0]  busy_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [NR];
  bit          bsy [NR];

  rfile_sb dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_addr    (wr_addr),
    .wr_enable  (wr_enable),
    .wr_data    (wr_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .busy_count (busy_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mem[r] = 32'h0;
      bsy[r] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(bsy[r]);
    return n;
  endfunction

  task automatic expect_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    bit byp = 1'b0;
    bit rh  = 1'b0;
    d = (a == 5'd0) ? 32'h0 : mem[a];
    b = (a == 5'd0) ? 1'b0 : bsy[a];
`ifdef RFILE_BYPASS_EN
    for (int p = 0; p < WP; p++) begin
      if (wr_enable[p] && wr_addr[p] == a && a != 5'd0) begin
        d = wr_data[p];
        byp = 1'b1;
      end
    end
    for (int p = 0; p < SP; p++) begin
      if (rsv_valid[p] && rsv_addr[p] == a) rh = 1'b1;
    end
    if (byp) b = rh;
`endif
  endtask

  task automatic idle();
    for (int q = 0; q < RP; q++) rd_addr[q] = 5'd0;
    for (int p = 0; p < WP; p++) begin
      wr_addr[p] = 5'd0;
      wr_data[p] = 32'h0;
    end
    for (int p = 0; p < SP; p++) rsv_addr[p] = 5'd0;
    wr_enable = '0;
    rsv_valid = '0;
  endtask

  // Settle combinational outputs and compare every read port and the counter.
  task automatic settle(input string tag);
    logic [31:0] d;
    logic        b;
    #1;
    for (int q = 0; q < RP; q++) begin
      expect_read(rd_addr[q], d, b);
      chk({tag, "_data"}, rd_data[q], d);
      chk({tag, "_busy"}, 32'(rd_busy[q]), 32'(b));
    end
    chk({tag, "_count"}, 32'(busy_count), 32'(model_count()));
  endtask

  // Clock edge: apply this cycle's writes and reservations to the model.
  task automatic tick();
    bit setb [NR];
    bit clrb [NR];
    @(posedge clock);
    for (int r = 0; r < NR; r++) begin
      setb[r] = 1'b0;
      clrb[r] = 1'b0;
    end
    for (int p = 0; p < WP; p++) begin
      if (wr_enable[p] && wr_addr[p] != 5'd0) begin
        mem[wr_addr[p]] = wr_data[p];
        clrb[wr_addr[p]] = 1'b1;
      end
    end
    for (int p = 0; p < SP; p++) begin
      if (rsv_valid[p] && rsv_addr[p] != 5'd0) setb[rsv_addr[p]] = 1'b1;
    end
    for (int r = 0; r < NR; r++) begin
      if (setb[r]) bsy[r] = 1'b1;
      else if (clrb[r]) bsy[r] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    settle("in_reset");
    reset_n = 1'b1;

    // Every register reads zero and idle after reset.
    for (int i = 0; i < NR / RP; i++) begin
      @(negedge clock);
      idle();
      for (int q = 0; q < RP; q++) rd_addr[q] = 5'(i * RP + q);
      settle("post_reset");
      for (int q = 0; q < RP; q++) chk("post_reset_zero", rd_data[q], 32'h0);
      tick();
    end

    // Two ports write r5 in the same cycle; the higher-index port wins.
    @(negedge clock); idle();
    wr_enable[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'h11;
    wr_enable[3] = 1'b1; wr_addr[3] = 5'd5; wr_data[3] = 32'h33;
    settle("prio_wr"); tick();
    @(negedge clock); idle(); rd_addr[0] = 5'd5;
    settle("prio_rd"); chk("prio_const", rd_data[0], 32'h33); tick();

    // Reserve, release by writeback, then reserve and write together.
    @(negedge clock); idle(); rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd7;
    settle("rsv7"); tick();
    @(negedge clock); idle(); rd_addr[0] = 5'd7;
    settle("rsv7_rd");
    chk("rsv7_busy", 32'(rd_busy[0]), 32'd1);
    chk("rsv7_cnt", 32'(busy_count), 32'd1);
    tick();
    @(negedge clock); idle(); wr_enable[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'hAB;
    settle("wr7"); tick();
    @(negedge clock); idle(); rd_addr[0] = 5'd7;
    rsv_valid[1] = 1'b1; rsv_addr[1] = 5'd7;
    wr_enable[2] = 1'b1; wr_addr[2] = 5'd7; wr_data[2] = 32'hCD;
    settle("rel7");
    chk("rel7_cnt", 32'(busy_count), 32'd0);
`ifndef RFILE_BYPASS_EN
    chk("rel7_data", rd_data[0], 32'hAB);
    chk("rel7_busy", 32'(rd_busy[0]), 32'd0);
`endif
    tick();
    @(negedge clock); idle(); rd_addr[0] = 5'd7;
    settle("both7");
    chk("both7_busy", 32'(rd_busy[0]), 32'd1);
    chk("both7_data", rd_data[0], 32'hCD);
    tick();

    // Register 0 is hardwired: writes and reserves are ignored.
    @(negedge clock); idle();
    wr_enable[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF;
    rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd0;
    settle("zero_wr"); tick();
    @(negedge clock); idle(); rd_addr[1] = 5'd0;
    settle("zero_rd");
    chk("zero_data", rd_data[1], 32'h0);
    chk("zero_busy", 32'(rd_busy[1]), 32'd0);
    chk("zero_cnt", 32'(busy_count), 32'd1);
    tick();

    // Read r3 in the same cycle it is written.
    @(negedge clock); idle();
    wr_enable[1] = 1'b1; wr_addr[1] = 5'd3; wr_data[1] = 32'hDEAD; rd_addr[2] = 5'd3;
    settle("byp_same");
`ifdef RFILE_BYPASS_EN
    chk("byp_same_const", rd_data[2], 32'hDEAD);
`else
    chk("byp_same_const", rd_data[2], 32'h0);
`endif
    tick();
    @(negedge clock); idle(); rd_addr[2] = 5'd3;
    settle("byp_next"); chk("byp_next_const", rd_data[2], 32'hDEAD); tick();

    // Random traffic with address collisions.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); idle();
      for (int q = 0; q < RP; q++) rd_addr[q] = 5'($urandom_range(0, 31));
      for (int p = 0; p < WP; p++) begin
        wr_enable[p] = ($urandom_range(0, 1) == 1);
        wr_addr[p]   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_data[p]   = $urandom;
      end
      for (int p = 0; p < SP; p++) begin
        rsv_valid[p] = ($urandom_range(0, 2) == 0);
        rsv_addr[p]  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      settle("rand"); tick();
    end

    // Reserve r9, then assert reset between edges: everything clears at once.
    @(negedge clock); idle(); rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd9;
    settle("pre_rst"); tick();
    @(negedge clock); idle();
    rd_addr[0] = 5'd9; rd_addr[1] = 5'd5; rd_addr[2] = 5'd7; rd_addr[3] = 5'd3;
    reset_n = 1'b0;
    #1;
    for (int q = 0; q < RP; q++) begin
      chk("mid_rst_data", rd_data[q], 32'h0);
      chk("mid_rst_busy", 32'(rd_busy[q]), 32'd0);
    end
    chk("mid_rst_cnt", 32'(busy_count), 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wr_enable[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h1234;
    rsv_valid[1] = 1'b1; rsv_addr[1] = 5'd4;
    settle("after_rst"); tick();
    @(negedge clock); idle(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd4;
    settle("after_rst_rd");
    chk("after_rst_data", rd_data[0], 32'h1234);
    chk("after_rst_busy", 32'(rd_busy[1]), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
